// File: rtl/uart_frame_rx_pkg.sv
// Shared constants for the multi-byte UART frame receiver.
// Holds state encodings, width helpers and the default timeout.
package uart_frame_rx_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;

    localparam int DEF_CLKS_PER_BIT = 35;
    localparam int DEFAULT_TIMEOUT  = 20 * DEF_CLKS_PER_BIT;

    function automatic int frame_cw(input int n_bytes);
        return $clog2(n_bytes + 1);
    endfunction

    function automatic int tmo_w(input int clks);
        return (clks > 0) ? $clog2(clks + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte deserialiser; one-cycle rx_dv_o pulse per received byte.
// Deliberately has no reset: it free-runs off the idle-high line.
module uart_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rx_i,
    output logic       rx_dv_o,
    output logic [7:0] rx_byte_o
);

    localparam int CCW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CCW-1:0] LAST = CCW'(CLKS_PER_BIT - 1);
    localparam logic [CCW-1:0] MID  = CCW'((CLKS_PER_BIT - 1) / 2);

    logic [1:0]     sync_q;
    logic [2:0]     state_q, state_d;
    logic [CCW-1:0] cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     byte_q, byte_d;
    logic           dv_q, dv_d;
    logic           rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == MID) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CCW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + CCW'(1);
                end else begin
                    cnt_d          = '0;
                    byte_d[idx_q]  = rx_s;
                    if (idx_q == 3'd7) state_d = RX_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + CCW'(1);
                end else begin
                    cnt_d   = '0;
                    dv_d    = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        sync_q  <= {sync_q[0], rx_i};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        byte_q  <= byte_d;
        dv_q    <= dv_d;
    end

    assign rx_dv_o   = dv_q;
    assign rx_byte_o = byte_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame receiver: packs uart_rx bytes into a frame word
// with per-transfer length, selectable byte order, timeout and abort.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int N_BYTES_MAX  = 16,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT,
    parameter bit MSB_FIRST    = 1'b1,
    localparam int CW          = frame_cw(N_BYTES_MAX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CW-1:0]            len,
    input  logic                     abort,
    input  logic                     rx_pin,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [CW-1:0]            rx_count,
    output logic [N_BYTES_MAX*8-1:0] rx_data
);

    localparam int DW = N_BYTES_MAX * 8;
    localparam int TW = tmo_w(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] NMAX     = CW'(N_BYTES_MAX);

    logic          rx_dv;
    logic [7:0]    rx_byte;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          tmo_q, tmo_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] cnt_inc;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rx_i     (rx_pin),
        .rx_dv_o  (rx_dv),
        .rx_byte_o(rx_byte)
    );

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        armed_d = armed_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    armed_d = 1'b0;
                    tcnt_d  = '0;
                    if (len != '0 && len <= NMAX) begin
                        len_d   = len;
                        done_d  = 1'b0;
                        state_d = ST_BUSY;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // Priority: abort, then byte accept, then timeout expiry
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    armed_d = 1'b0;
                end else if (rx_dv) begin
                    if (MSB_FIRST) data_d = {data_q[DW-9:0], rx_byte};
                    else           data_d[8*cnt_q +: 8] = rx_byte;
                    cnt_d   = cnt_inc;
                    tcnt_d  = '0;
                    armed_d = 1'b1;
                    if (cnt_inc == len_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else if (TIMEOUT_CLKS != 0 && armed_q) begin
                    if (tcnt_q == TMO_LAST) begin
                        state_d = ST_IDLE;
                        tmo_d   = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            armed_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            armed_q <= armed_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign done     = done_q;
    assign timeout  = tmo_q;
    assign rx_count = cnt_q;
    assign rx_data  = data_q;

endmodule
